pipeline_commit_monitor: RTL and testbench
==========================================

// Module: pipeline_commit_monitor
// PURPOSE
//  Parametrised multi-lane commit tracker for the mp4 RV32I core: assigns RVFI order numbers to
//  committed instructions, detects the branch-to-self halt idiom and runs a no-commit watchdog.
//  Sits between the core's writeback/commit stage(s) and the RVFI/testbench logic.
//  Replaces the single-lane order counter and the single-cycle halt compare.
// PARAMETERS
//  COMMIT_WIDTH   1      commit lanes per cycle (1..4); lane 0 is oldest
//  ORDER_W        64     width of the order counter
//  HALT_REPEAT    2      consecutive self-loop commits of the same PC required to halt (>=1)
//  TIMEOUT_CYCLES 100000 cycles with no commit before timeout (>=1); counter is 32 bits
// PORTS
//  clk            in  1                  core clock
//  reset_n        in  1                  async active-low reset
//  clear          in  1                  sync: restart tracking (same effect as reset)
//  commit_valid   in  COMMIT_WIDTH       lane i commits this cycle
//  commit_pc      in  32*COMMIT_WIDTH    PC of lane i
//  commit_pc_next in  32*COMMIT_WIDTH    next PC of lane i
//  commit_cf      in  COMMIT_WIDTH       lane i is a branch/jal/jalr
//  commit_order   out ORDER_W*COMMIT_WIDTH order assigned to lane i (combinational)
//  order_q        out ORDER_W            count of commits accepted so far
//  halt           out 1                  sticky halt detected
//  timeout        out 1                  sticky watchdog expiry
//  lane_error     out 1                  sticky: non-contiguous commit_valid seen
//  stat_cf_count  out 32                 committed control-flow instructions (see CONFIGURATION)
//  stat_cycles    out 32                 cycles spent in RUN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset/clear: state=RUN, order_q=0, halt=timeout=lane_error=0, idle counter=0, repeat count=0,
//    last-loop PC=0, stats=0. clear takes priority over every other update in the same cycle.
//  - States: RUN -> HALTED (halt) | TIMED_OUT (timeout). HALTED/TIMED_OUT terminal until reset/clear.
//  - RUN: commit_order[i] = order_q + popcount(commit_valid[i-1:0]); order_q += popcount(commit_valid)
//    at clk edge; wraps modulo 2^ORDER_W. Outside RUN commits are ignored, order_q frozen.
//  - commit_order driven for every lane regardless of valid; consumers qualify with commit_valid.
//  - Contiguity: valid lanes must be 0..k-1. A gap (e.g. 4'b0101) sets lane_error; all valid lanes
//    are still counted.
//  - Self-loop: lane with valid & cf & pc_next==pc. Oldest such lane per cycle considered.
//    If its PC equals last-loop PC, repeat++ (saturating), else repeat=1 and last-loop PC := PC.
//    A cycle with commits but no self-loop resets repeat to 0. Cycles with no commit keep repeat.
//    When updated repeat reaches HALT_REPEAT, halt=1 the next cycle (registered) and state=HALTED.
//  - Watchdog: idle counter cleared on any commit, else incremented; reaching TIMEOUT_CYCLES sets
//    timeout=1, state=TIMED_OUT on the same edge. Halt and timeout on same edge: halt wins.
//  - Async reset mid-operation: all registers to reset values immediately; outputs low.
// CONFIGURATION
//  COMMIT_MON_STATS_EN defined: stat_cf_count counts valid & cf lanes per cycle in RUN;
//    stat_cycles increments every RUN cycle; both saturate at 32'hFFFF_FFFF.
//  Not defined: counter registers omitted; stat_cf_count and stat_cycles tied to 0.
// TESTING
//  1. W=1: commit_valid=1 for 5 cycles -> commit_order 0,1,2,3,4; order_q=5.
//  2. W=4: valid=4'b0111 then 4'b1111 -> orders {0,1,2}, then {3,4,5,6}; order_q=7; lane_error=0.
//  3. W=2: valid=2'b10 -> lane_error=1 next cycle, order_q increments by 1.
//  4. HALT_REPEAT=2: cf commit pc=pc_next=0x60 twice -> halt=1 after 2nd; later commits leave order_q.
//  5. Self-loop 0x60, then non-loop commit, then 0x60 -> repeat restarts, no halt.
//  6. TIMEOUT_CYCLES=8: no commits 8 cycles -> timeout=1; clear -> all zero, RUN, order restarts 0.

Source files
------------

// File: rtl/pipeline_commit_monitor.sv
// Multi-lane RVFI commit order tracker with self-loop halt detection and watchdog.
// Define COMMIT_MON_STATS_EN to build the control-flow and cycle statistic counters.
module pipeline_commit_monitor #(
    parameter int COMMIT_WIDTH   = 1,
    parameter int ORDER_W        = 64,
    parameter int HALT_REPEAT    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic [COMMIT_WIDTH-1:0]         commit_valid,
    input  logic [32*COMMIT_WIDTH-1:0]      commit_pc,
    input  logic [32*COMMIT_WIDTH-1:0]      commit_pc_next,
    input  logic [COMMIT_WIDTH-1:0]         commit_cf,
    output logic [ORDER_W*COMMIT_WIDTH-1:0] commit_order,
    output logic [ORDER_W-1:0]              order_q,
    output logic                            halt,
    output logic                            timeout,
    output logic                            lane_error,
    output logic [31:0]                     stat_cf_count,
    output logic [31:0]                     stat_cycles
);

    typedef enum logic [1:0] {RUN, HALTED, TIMED_OUT} state_t;

    state_t             state;
    logic [ORDER_W-1:0] order_r;
    logic [31:0]        idle_cnt;
    logic [31:0]        rep_cnt;
    logic [31:0]        loop_pc;
    logic               halt_r;
    logic               timeout_r;
    logic               lane_err_r;

    logic [ORDER_W-1:0] prefix;
    logic               any_commit;
    logic               gap;
    logic               seen_hole;
    logic               loop_hit;
    logic [31:0]        loop_pc_sel;
    logic [31:0]        rep_next;
    logic [31:0]        idle_next;
    logic               halt_hit;
    logic               timeout_hit;

    // Lane scan: running order per lane, gap detection, oldest self-loop lane
    always_comb begin
        prefix       = order_r;
        any_commit   = 1'b0;
        gap          = 1'b0;
        seen_hole    = 1'b0;
        loop_hit     = 1'b0;
        loop_pc_sel  = '0;
        commit_order = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_order[i*ORDER_W +: ORDER_W] = prefix;
            if (commit_valid[i]) begin
                prefix     = prefix + ORDER_W'(1);
                any_commit = 1'b1;
                if (seen_hole)
                    gap = 1'b1;
                if (!loop_hit && commit_cf[i] &&
                    commit_pc_next[i*32 +: 32] == commit_pc[i*32 +: 32]) begin
                    loop_hit    = 1'b1;
                    loop_pc_sel = commit_pc[i*32 +: 32];
                end
            end else begin
                seen_hole = 1'b1;
            end
        end
    end

    // Next repeat count and idle count, plus the halt/timeout triggers they imply
    always_comb begin
        idle_next = idle_cnt + 32'd1;
        rep_next  = rep_cnt;
        if (any_commit) begin
            if (!loop_hit)
                rep_next = '0;
            else if (loop_pc_sel != loop_pc)
                rep_next = 32'd1;
            else if (rep_cnt != '1)
                rep_next = rep_cnt + 32'd1;
        end
        halt_hit    = loop_hit && (rep_next >= 32'(HALT_REPEAT));
        timeout_hit = !any_commit && (idle_next >= 32'(TIMEOUT_CYCLES));
    end

    // Tracking state: order counter, sticky flags, halt/watchdog FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            order_r    <= '0;
            idle_cnt   <= '0;
            rep_cnt    <= '0;
            loop_pc    <= '0;
            halt_r     <= 1'b0;
            timeout_r  <= 1'b0;
            lane_err_r <= 1'b0;
        end else if (clear) begin
            state      <= RUN;
            order_r    <= '0;
            idle_cnt   <= '0;
            rep_cnt    <= '0;
            loop_pc    <= '0;
            halt_r     <= 1'b0;
            timeout_r  <= 1'b0;
            lane_err_r <= 1'b0;
        end else if (state == RUN) begin
            order_r  <= prefix;
            rep_cnt  <= rep_next;
            idle_cnt <= any_commit ? '0 : idle_next;
            if (gap)
                lane_err_r <= 1'b1;
            if (loop_hit)
                loop_pc <= loop_pc_sel;
            if (halt_hit) begin
                halt_r <= 1'b1;
                state  <= HALTED;
            end else if (timeout_hit) begin
                timeout_r <= 1'b1;
                state     <= TIMED_OUT;
            end
        end
    end

    assign order_q    = order_r;
    assign halt       = halt_r;
    assign timeout    = timeout_r;
    assign lane_error = lane_err_r;

`ifdef COMMIT_MON_STATS_EN
    logic [31:0] cf_cnt;
    logic [31:0] cyc_cnt;
    logic [31:0] cf_add;
    logic [32:0] cf_sum;

    // Count committed control-flow lanes this cycle
    always_comb begin
        cf_add = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i] && commit_cf[i])
                cf_add = cf_add + 32'd1;
        end
    end

    assign cf_sum = {1'b0, cf_cnt} + {1'b0, cf_add};

    // Saturating statistics, advancing only while tracking is live
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cf_cnt  <= '0;
            cyc_cnt <= '0;
        end else if (clear) begin
            cf_cnt  <= '0;
            cyc_cnt <= '0;
        end else if (state == RUN) begin
            cf_cnt  <= cf_sum[32] ? '1 : cf_sum[31:0];
            cyc_cnt <= (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
        end
    end

    assign stat_cf_count = cf_cnt;
    assign stat_cycles   = cyc_cnt;
`else
    assign stat_cf_count = '0;
    assign stat_cycles   = '0;
`endif

endmodule

// File: tb/tb_pipeline_commit_monitor.sv
// Bench for pipeline_commit_monitor: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_commit_monitor;

    localparam int W  = 4;
    localparam int OW = 8;
    localparam int HR = 2;
    localparam int TO = 8;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            clear = 1'b0;
    logic [W-1:0]    commit_valid = '0;
    logic [W-1:0]    commit_cf = '0;
    logic [31:0]     pc [W];
    logic [31:0]     pcn [W];
    logic [32*W-1:0] commit_pc;
    logic [32*W-1:0] commit_pc_next;
    logic [OW*W-1:0] commit_order;
    logic [OW-1:0]   order_q;
    logic            halt;
    logic            timeout;
    logic            lane_error;
    logic [31:0]     stat_cf_count;
    logic [31:0]     stat_cycles;

    int n_checks = 0;
    int n_fail = 0;

    // behavioural model state
    int          m_order = 0;
    bit          m_halt = 0;
    bit          m_to = 0;
    bit          m_err = 0;
    int          m_idle = 0;
    longint      m_rep = 0;
    logic [31:0] m_lpc = '0;
    longint      m_cf = 0;
    longint      m_cyc = 0;

    always #5 clk = ~clk;

    always_comb begin
        commit_pc      = '0;
        commit_pc_next = '0;
        for (int i = 0; i < W; i++) begin
            commit_pc[i*32 +: 32]      = pc[i];
            commit_pc_next[i*32 +: 32] = pcn[i];
        end
    end

    pipeline_commit_monitor #(
        .COMMIT_WIDTH(W),
        .ORDER_W(OW),
        .HALT_REPEAT(HR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .commit_valid(commit_valid),
        .commit_pc(commit_pc),
        .commit_pc_next(commit_pc_next),
        .commit_cf(commit_cf),
        .commit_order(commit_order),
        .order_q(order_q),
        .halt(halt),
        .timeout(timeout),
        .lane_error(lane_error),
        .stat_cf_count(stat_cf_count),
        .stat_cycles(stat_cycles)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [OW-1:0] lane_ord(int i);
        return commit_order[i*OW +: OW];
    endfunction

    function automatic void m_reset();
        m_order = 0;
        m_halt  = 0;
        m_to    = 0;
        m_err   = 0;
        m_idle  = 0;
        m_rep   = 0;
        m_lpc   = '0;
        m_cf    = 0;
        m_cyc   = 0;
    endfunction

    function automatic void m_step();
        int n;
        int nc;
        int lp;
        n  = 0;
        nc = 0;
        lp = -1;
        for (int i = 0; i < W; i++) begin
            if (commit_valid[i]) n++;
            if (commit_valid[i] && commit_cf[i]) nc++;
        end
        for (int i = W - 1; i >= 0; i--)
            if (commit_valid[i] && commit_cf[i] && pc[i] == pcn[i]) lp = i;
        m_cyc = (m_cyc + 1 > SAT) ? SAT : m_cyc + 1;
        m_cf  = (m_cf + nc > SAT) ? SAT : m_cf + nc;
        m_order = (m_order + n) % (1 << OW);
        if (commit_valid != W'((1 << n) - 1)) m_err = 1;
        if (n == 0) begin
            m_idle++;
            if (m_idle >= TO) m_to = 1;
        end else begin
            m_idle = 0;
            if (lp < 0) begin
                m_rep = 0;
            end else begin
                if (pc[lp] == m_lpc)
                    m_rep = (m_rep < SAT) ? m_rep + 1 : m_rep;
                else
                    m_rep = 1;
                m_lpc = pc[lp];
                if (m_rep >= HR) m_halt = 1;
            end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear)
            m_reset();
        else if (!m_halt && !m_to)
            m_step();
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        int below;
        #2;
        chk("order_q", 64'(order_q), 64'(m_order));
        chk("halt", 64'(halt), 64'(m_halt));
        chk("timeout", 64'(timeout), 64'(m_to));
        chk("lane_error", 64'(lane_error), 64'(m_err));
        below = 0;
        for (int i = 0; i < W; i++) begin
            chk($sformatf("commit_order[%0d]", i), 64'(lane_ord(i)),
                64'((m_order + below) % (1 << OW)));
            if (commit_valid[i]) below++;
        end
`ifdef COMMIT_MON_STATS_EN
        chk("stat_cf_count", 64'(stat_cf_count), 64'(m_cf));
        chk("stat_cycles", 64'(stat_cycles), 64'(m_cyc));
`else
        chk("stat_cf_count", 64'(stat_cf_count), 64'd0);
        chk("stat_cycles", 64'(stat_cycles), 64'd0);
`endif
    end

    task automatic step(input logic [W-1:0] v, input logic [W-1:0] cf,
                        input logic [31:0] p0, input logic [31:0] pn0,
                        input logic clr);
        @(negedge clk);
        commit_valid = v;
        commit_cf    = cf;
        clear        = clr;
        for (int i = 0; i < W; i++) begin
            pc[i]  = p0 + 32'(4 * i);
            pcn[i] = (i == 0) ? pn0 : p0 + 32'(4 * i + 4);
        end
    endtask

    task automatic idle();
        step('0, '0, 32'h100, 32'h104, 1'b0);
    endtask

    task automatic do_clear();
        step('0, '0, 32'h100, 32'h104, 1'b1);
    endtask

    task automatic rand_cycle(input logic clr, input logic quiet);
        int k;
        @(negedge clk);
        k = $urandom_range(0, 4);
        if (quiet)
            commit_valid = '0;
        else if ($urandom_range(0, 9) == 0)
            commit_valid = W'($urandom);
        else
            commit_valid = W'((1 << k) - 1);
        for (int i = 0; i < W; i++) begin
            pc[i]  = 32'h60 + 32'(4 * $urandom_range(0, 2));
            pcn[i] = ($urandom_range(0, 7) == 0) ? pc[i] : pc[i] + 32'd4;
            commit_cf[i] = 1'($urandom);
        end
        clear = clr;
    endtask

    initial begin
        int stuck;
        int burst;
        for (int i = 0; i < W; i++) begin
            pc[i]  = '0;
            pcn[i] = 32'd4;
        end
        repeat (2) idle();
        #3;
        chk("reset_order_q", 64'(order_q), 64'd0);
        chk("reset_halt", 64'(halt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single-lane ordering
        do_clear();
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, '0, 32'h10, 32'h14, 1'b0);
            #3;
            chk("t1_order", 64'(lane_ord(0)), 64'(c));
        end
        idle();
        #3;
        chk("t1_order_q", 64'(order_q), 64'd5);

        // four lanes
        do_clear();
        step(4'b0111, '0, 32'h20, 32'h24, 1'b0);
        #3;
        chk("t2_l0", 64'(lane_ord(0)), 64'd0);
        chk("t2_l2", 64'(lane_ord(2)), 64'd2);
        step(4'b1111, '0, 32'h30, 32'h34, 1'b0);
        #3;
        chk("t2_l0b", 64'(lane_ord(0)), 64'd3);
        chk("t2_l3b", 64'(lane_ord(3)), 64'd6);
        idle();
        #3;
        chk("t2_order_q", 64'(order_q), 64'd7);
        chk("t2_lane_error", 64'(lane_error), 64'd0);

        // gap in valid lanes
        do_clear();
        step(4'b0010, '0, 32'h40, 32'h44, 1'b0);
        idle();
        #3;
        chk("t3_lane_error", 64'(lane_error), 64'd1);
        chk("t3_order_q", 64'(order_q), 64'd1);
        do_clear();
        step(4'b0101, '0, 32'h40, 32'h44, 1'b0);
        idle();
        #3;
        chk("t3b_lane_error", 64'(lane_error), 64'd1);
        chk("t3b_order_q", 64'(order_q), 64'd2);

        // halt on repeated self-loop
        do_clear();
        step(4'b0001, 4'b0001, 32'h60, 32'h60, 1'b0);
        step(4'b0001, 4'b0001, 32'h60, 32'h60, 1'b0);
        #3;
        chk("t4_halt_early", 64'(halt), 64'd0);
        idle();
        #3;
        chk("t4_halt", 64'(halt), 64'd1);
        chk("t4_order_q", 64'(order_q), 64'd2);
        step(4'b1111, '0, 32'h200, 32'h204, 1'b0);
        idle();
        #3;
        chk("t4_frozen", 64'(order_q), 64'd2);

        // non-loop commit restarts the repeat count
        do_clear();
        step(4'b0001, 4'b0001, 32'h60, 32'h60, 1'b0);
        step(4'b0001, 4'b0001, 32'h64, 32'h68, 1'b0);
        step(4'b0001, 4'b0001, 32'h60, 32'h60, 1'b0);
        idle();
        #3;
        chk("t5_no_halt", 64'(halt), 64'd0);
        chk("t5_order_q", 64'(order_q), 64'd3);
        step(4'b0001, 4'b0001, 32'h60, 32'h60, 1'b0);
        idle();
        #3;
        chk("t5_halt", 64'(halt), 64'd1);

        // watchdog and clear
        do_clear();
        repeat (8) idle();
        #3;
        chk("t6_no_timeout", 64'(timeout), 64'd0);
        idle();
        #3;
        chk("t6_timeout", 64'(timeout), 64'd1);
        do_clear();
        step(4'b0001, '0, 32'h80, 32'h84, 1'b0);
        #3;
        chk("t6_timeout_clr", 64'(timeout), 64'd0);
        chk("t6_order_restart", 64'(lane_ord(0)), 64'd0);

        // order counter wrap
        do_clear();
        repeat (65) step(4'b1111, '0, 32'h300, 32'h304, 1'b0);
        idle();
        #3;
        chk("wrap_order_q", 64'(order_q), 64'd4);

        // async reset mid-operation
        step(4'b0011, '0, 32'h300, 32'h304, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_order_q", 64'(order_q), 64'd0);
        chk("async_lane_error", 64'(lane_error), 64'd0);
        idle();
        #1;
        reset_n = 1'b1;

        // randomized traffic
        stuck = 0;
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            logic clr;
            logic quiet;
            clr = 1'b0;
            if (m_halt || m_to) begin
                stuck++;
                if (stuck > 2) begin
                    clr   = 1'b1;
                    stuck = 0;
                end
            end else if ($urandom_range(0, 199) == 0) begin
                clr = 1'b1;
            end
            if (burst > 0) begin
                burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                burst = 9;
            end
            quiet = (burst > 0);
            rand_cycle(clr, quiet);
        end
        idle();
        idle();
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
